// File: rtl/channel_pkg.sv
// -----------------------------------------------------------------------------
// channel_pkg
// Shared constants for the channel receive FIFO and its storage.
//   XFER_COUNT_W               : width of the optional input-transfer counter
//   CHANNEL_FIFO_DEPTH_DEFAULT : default number of FIFO entries
// -----------------------------------------------------------------------------
package channel_pkg;

    localparam int XFER_COUNT_W               = 32;
    localparam int CHANNEL_FIFO_DEPTH_DEFAULT = 4;

endpackage : channel_pkg

// File: rtl/channel_fifo_mem.sv
// -----------------------------------------------------------------------------
// channel_fifo_mem
// DEPTH x N storage array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//
// Ports:
//   clk_i    : clock, writes happen on posedge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module channel_fifo_mem
    import channel_pkg::*;
#(
    parameter int N     = 1,
    parameter int DEPTH = CHANNEL_FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [N-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [N-1:0]             rdata_o
);

    logic [N-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : channel_fifo_mem

// File: rtl/channel_rx_fifo.sv
// -----------------------------------------------------------------------------
// channel_rx_fifo
// Receive FIFO between two valid/acknowledge channels. A word is registered
// into storage on an input transfer and becomes visible downstream from the
// next cycle on (no fall-through). DEPTH must be a power of two, >= 2.
//
// Handshake: a transfer happens on a posedge where valid and acknowledge are
// both 1 on the same channel. in_a depends only on registered occupancy (and
// the reset pin), never on in_v or out_a. out_v/out_d present the oldest word.
//
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset, discards all stored words
//   in_d/in_v  : upstream data / valid
//   in_a       : upstream acknowledge (count < DEPTH)
//   out_d/out_v: downstream data / valid (count != 0)
//   out_a      : downstream acknowledge
//   count      : occupancy 0..DEPTH
//   xfer_count : 32-bit input-transfer counter, only present when the macro
//                CHANNEL_RX_FIFO_XFER_COUNT_EN is defined
// -----------------------------------------------------------------------------
module channel_rx_fifo
    import channel_pkg::*;
#(
    parameter int N     = 1,
    parameter int DEPTH = CHANNEL_FIFO_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           in_d,
    input  logic                   in_v,
    output logic                   in_a,
    output logic [N-1:0]           out_d,
    output logic                   out_v,
    input  logic                   out_a,
    output logic [$clog2(DEPTH):0] count
`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
    ,
    output logic [XFER_COUNT_W-1:0] xfer_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          in_xfer;
    logic          out_xfer;

    // count_q is already 0 during reset, so in_a would read 1 without the
    // reset gate; the gate keeps the upstream from seeing an acknowledge
    // while the block is held in reset.
    assign in_a     = reset & (count_q < FULL_C);
    assign out_v    = (count_q != '0);
    assign in_xfer  = in_v & in_a;
    assign out_xfer = out_v & out_a;
    assign count    = count_q;

    // Pointers are exactly AW bits so they wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_xfer) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (out_xfer) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({in_xfer, out_xfer})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    channel_fifo_mem #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (in_xfer),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_d),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_d)
    );

`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
    logic [XFER_COUNT_W-1:0] xfer_count_q, xfer_count_d;

    // Free-running wrap at 2^32-1 -> 0 comes from the natural overflow.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (in_xfer) begin
            xfer_count_d = xfer_count_q + XFER_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule : channel_rx_fifo

// File: tb/tb_channel_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_channel_rx_fifo
// Bench for channel_rx_fifo with N=4, DEPTH=4. Inputs change 1 time unit after
// posedge; the monitor samples on negedge. The reference model is a queue of
// accepted words: its size is the expected occupancy and its head the expected
// output word. Works with or without CHANNEL_RX_FIFO_XFER_COUNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_channel_rx_fifo;
    import channel_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  in_d;
    logic          in_v;
    logic          in_a;
    logic [N-1:0]  out_d;
    logic          out_v;
    logic          out_a;
    logic [CW-1:0] count;
`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
    logic [XFER_COUNT_W-1:0] xfer_count;
`endif

    channel_rx_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_d       (in_d),
        .in_v       (in_v),
        .in_a       (in_a),
        .out_d      (out_d),
        .out_v      (out_v),
        .out_a      (out_a),
        .count      (count)
`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [N-1:0] exp_q[$];
    int           n_checks   = 0;
    int           n_errors   = 0;
    int           n_pops     = 0;
    longint       xfer_model = 0;
    bit           stress_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            xfer_model = 0;
            n_pops     = 0;
            check("rst_count", 32'(count), 32'd0);
            check("rst_in_a", 32'(in_a), 32'd0);
            check("rst_out_v", 32'(out_v), 32'd0);
        end else begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
            check("in_a", 32'(in_a), 32'(exp_q.size() < DEPTH));
            check("out_v", 32'(out_v), 32'(exp_q.size() != 0));
`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
            check("xfer_count", xfer_count, 32'(xfer_model));
`endif
            if (out_v && out_a) begin
                if (exp_q.size() == 0) begin
                    check("pop_on_empty", 32'd1, 32'd0);
                end else begin
                    check("out_d", 32'(out_d), 32'(exp_q.pop_front()));
                    n_pops++;
                end
            end
            if (in_v && in_a) begin
                exp_q.push_back(in_d);
                xfer_model++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until a transfer happens.
    task automatic push_word(input logic [N-1:0] d);
        int   waited = 0;
        logic acc;
        in_v = 1'b1;
        in_d = d;
        forever begin
            @(negedge clk);
            acc = in_a;
            step();
            if (acc) break;
            waited++;
            if (waited > 500) begin
                fail_now("push_timeout");
                break;
            end
        end
        in_v = 1'b0;
    endtask

    // Hold out_a until the model says the FIFO is empty.
    task automatic drain();
        int waited = 0;
        out_a = 1'b1;
        while (exp_q.size() != 0 || count != 0) begin
            step();
            waited++;
            if (waited > 500) begin
                fail_now("drain_timeout");
                break;
            end
        end
        out_a = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        #1;
        check("rel_in_a", 32'(in_a), 32'd1);
        check("rel_count", 32'(count), 32'd0);
        check("rel_out_v", 32'(out_v), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        in_v  = 1'b0;
        in_d  = '0;
        out_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
        check("idle_xfer_count", xfer_count, 32'd0);
`endif
        repeat (2) step();

        // Fill with out_a low, then offer a fifth word that must be held off.
        for (int i = 1; i <= 4; i++) push_word(N'(i));
        in_v = 1'b1;
        in_d = 4'h5;
        repeat (2) step();
        @(negedge clk);
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_a", 32'(in_a), 32'd0);
        check("fill_out_d", 32'(out_d), 32'h1);
        step();
        in_v = 1'b0;

        // Drain exactly four cycles: scoreboard checks 1,2,3,4 order.
        out_a = 1'b1;
        repeat (4) step();
        out_a = 1'b0;
        @(negedge clk);
        check("drain_count", 32'(count), 32'd0);
        check("drain_out_v", 32'(out_v), 32'd0);
        step();

        // Full plus a single pop while a word is waiting upstream.
        for (int i = 6; i <= 9; i++) push_word(N'(i));
        in_v = 1'b1;
        in_d = 4'h5;
        step();
        out_a = 1'b1;
        step();
        out_a = 1'b0;
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_in_a", 32'(in_a), 32'd1);
        step();
        in_v = 1'b0;
        check("fullpop_refill_count", 32'(count), 32'd4);
        check("fullpop_head", 32'(out_d), 32'h7);
        drain();

        // Reset with two words stored: everything drops at once.
        push_word(4'hB);
        push_word(4'hC);
        check("pre_rst_count", 32'(count), 32'd2);
        reset = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_out_v", 32'(out_v), 32'd0);
        check("async_rst_in_a", 32'(in_a), 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("post_rst_in_a", 32'(in_a), 32'd1);
        push_word(4'hA);
        check("post_rst_first", 32'(out_d), 32'hA);
        check("post_rst_out_v", 32'(out_v), 32'd1);
        drain();

        // Random stress from a fresh reset.
        do_reset();
        stress_on = 1'b1;
        fork
            begin
                int waited;
                for (int i = 0; i < 1000; i++) begin
                    int gap;
                    gap = $urandom_range(0, 5);
                    repeat (gap) step();
                    push_word(N'($urandom));
                end
                waited = 0;
                while (exp_q.size() != 0 && waited < 500) begin
                    step();
                    waited++;
                end
                if (waited >= 500) fail_now("stress_drain_timeout");
                stress_on = 1'b0;
            end
            begin
                while (stress_on) begin
                    int gap;
                    gap   = $urandom_range(0, 5);
                    out_a = 1'b0;
                    repeat (gap) step();
                    out_a = 1'b1;
                    step();
                end
                out_a = 1'b0;
            end
        join
        @(negedge clk);
        check("stress_pops", 32'(n_pops), 32'd1000);
        check("stress_left", 32'(exp_q.size()), 32'd0);
        check("stress_count", 32'(count), 32'd0);
`ifdef CHANNEL_RX_FIFO_XFER_COUNT_EN
        check("stress_xfer_count", xfer_count, 32'd1000);
`endif
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_channel_rx_fifo

// File: doc/channel_rx_fifo.md
CHANNEL_RX_FIFO -- requirements
Module: channel_rx_fifo

Interface
REQ-001 The block SHALL have parameter N, default 1, meaning the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on posedge clk.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (reset == 0 asserts).
REQ-005 Port in_d, input, N bits: upstream channel data.
REQ-006 Port in_v, input, 1 bit: upstream channel valid.
REQ-007 Port in_a, output, 1 bit: upstream channel acknowledge, driven by this block.
REQ-008 Port out_d, output, N bits: downstream channel data.
REQ-009 Port out_v, output, 1 bit: downstream channel valid.
REQ-010 Port out_a, input, 1 bit: downstream channel acknowledge.
REQ-011 Port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.

Function
REQ-012 An input transfer SHALL occur on a posedge where in_v == 1 and in_a == 1; an output transfer SHALL occur on a posedge where out_v == 1 and out_a == 1.
REQ-013 in_a SHALL be a combinational function of registered state only: in_a = (count < DEPTH); there SHALL be no combinational path from out_a or in_v to in_a.
REQ-014 out_v SHALL equal (count != 0); out_d SHALL equal the oldest stored word whenever out_v == 1; out_d is don't-care when out_v == 0.
REQ-015 Latency: a word accepted at posedge k SHALL be presented on out_d/out_v no earlier and no later than after posedge k (visible in cycle k+1) when the FIFO was empty; there is no same-cycle fall-through.
REQ-016 Order SHALL be strictly first-in first-out; no word SHALL be dropped or duplicated.
REQ-017 Write and read pointers SHALL each be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-018 count SHALL update per posedge: +1 on input only, -1 on output only, unchanged on both or neither.
REQ-019 Full (count == DEPTH): in_a == 0, no input transfer; a simultaneous output transfer SHALL reduce count to DEPTH-1, and in_a SHALL rise in the next cycle.
REQ-020 Empty (count == 0): out_v == 0, no output transfer regardless of out_a; an input transfer SHALL make count 1.
REQ-021 Simultaneous input and output transfers at 0 < count < DEPTH SHALL both complete with count unchanged.
REQ-022 in_v deasserting while in_a == 0 or out_a asserting while out_v == 0 SHALL have no effect.

Reset
REQ-023 While reset == 0: count = 0, pointers = 0, out_v = 0, in_a = 0.
REQ-024 After reset deasserts, in_a SHALL be 1 immediately, since count == 0 < DEPTH.
REQ-025 Storage contents SHALL NOT be reset.
REQ-026 Reset asserted mid-operation SHALL discard all stored words immediately and asynchronously.

Configuration
REQ-027 With macro CHANNEL_RX_FIFO_XFER_COUNT_EN defined, the block SHALL add output port xfer_count, 32 bits, counting input transfers since reset, reset value 0, wrapping from 2^32-1 to 0.
REQ-028 Without CHANNEL_RX_FIFO_XFER_COUNT_EN, port xfer_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package channel_pkg SHALL hold the constant XFER_COUNT_W = 32 and the default DEPTH constant CHANNEL_FIFO_DEPTH_DEFAULT = 4.
REQ-030 Storage SHALL be the sub-module channel_fifo_mem #(N, DEPTH): one write port and one asynchronous read port, written on posedge when its write enable is 1.
REQ-031 Pointer, count, and handshake logic SHALL reside in channel_rx_fifo.

Verification
REQ-032 Reset then idle: after reset release, count = 0, out_v = 0, in_a = 1, and with the macro enabled xfer_count = 0.
REQ-033 Fill with out_a = 0: N = 4, DEPTH = 4, push 0x1, 0x2, 0x3, 0x4 on consecutive cycles -> count = 4, in_a = 0, a 5th word 0x5 is held off, out_d = 0x1.
REQ-034 Drain: from full, hold out_a = 1 for 4 cycles -> outputs 0x1, 0x2, 0x3, 0x4 in order, then count = 0 and out_v = 0.
REQ-035 Full plus simultaneous pop: from full with in_v = 1, pulse out_a once -> count = 3 and in_a = 1 next cycle, and 0x5 is accepted on the following posedge.
REQ-036 Random stress: random in_v and out_a timing (0-5 clk delays), 1000 words, at least 10 wraps -> the output sequence equals the input sequence, count never exceeds 4, and xfer_count = 1000.
REQ-037 Mid-stream reset: assert reset with count = 2 -> count, out_v, and in_a drop to 0 within the same cycle, and the first word after release is the first word pushed after reset.
